// File: rtl/cordic_rr_sched.sv
// Shared CORDIC front end: round-robin arbitration across requesters, op issue to one core,
// and ID tagging so each core result is returned to the requester that issued it.
package cordic_wrapper_pkg;
    typedef logic [1:0] cordic_func;

    localparam cordic_func CORDIC_ROTATE  = 2'd0;
    localparam cordic_func CORDIC_VECTOR  = 2'd1;
    localparam cordic_func CORDIC_SINCOS  = 2'd2;
    localparam cordic_func CORDIC_ATAN    = 2'd3;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } cordic_data_in;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } cordic_data;
endpackage

module cordic_rr_sched
    import cordic_wrapper_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CORE_LAT = 14,
    parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  cordic_func    [NUM_REQ-1:0]   i_req_func,
    input  cordic_data_in [NUM_REQ-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_hold,
    output logic                          o_core_valid,
    output cordic_func                    o_core_func,
    output cordic_data_in                 o_core_data,
    input  logic                          i_core_valid,
    input  cordic_data                    i_core_data,
    output logic                          o_rsp_valid,
    output logic [ID_W-1:0]               o_rsp_id,
    output cordic_data                    o_rsp_data,
    output logic                          o_busy,
    output logic                          o_err
);

    // The count peaks at CORE_LAT+2: the accept in the response cycle lands before the decrement.
    localparam int                CNT_W   = $clog2(CORE_LAT + 3);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CORE_LAT + 2);
    localparam logic [ID_W-1:0]   PTR_RST = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]      ptr_r;
    logic [ID_W-1:0]      core_id_r;
    logic [ID_W-1:0]      cand_s;
    logic [ID_W-1:0]      grant_id_s;
    logic                 grant_s;
    logic [NUM_REQ-1:0]   ready_s;
    logic [CORE_LAT-1:0]  tag_vld_r;
    logic [ID_W-1:0]      tag_id_r [CORE_LAT];
    logic [CNT_W-1:0]     cnt_r;
    logic                 tail_vld_s;
    logic [ID_W-1:0]      tail_id_s;

    assign tail_vld_s = tag_vld_r[CORE_LAT-1];
    assign tail_id_s  = tag_id_r[CORE_LAT-1];

    // Round-robin search starting just past the last winner; hold and reset suppress the grant.
    always_comb begin
        grant_s    = 1'b0;
        grant_id_s = ptr_r;
        cand_s     = ptr_r;
        ready_s    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = ID_W'((int'(ptr_r) + k) % NUM_REQ);
            if (!grant_s && i_req_valid[cand_s]) begin
                grant_s    = 1'b1;
                grant_id_s = cand_s;
            end else begin
                grant_s    = grant_s;
            end
        end
        if (i_hold || i_rst) begin
            grant_s = 1'b0;
        end else begin
            grant_s = grant_s;
        end
        if (grant_s) begin
            ready_s[grant_id_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign o_req_ready = ready_s;

    // Issue register toward the core; operands hold when nothing is accepted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_r        <= PTR_RST;
            core_id_r    <= '0;
            o_core_valid <= 1'b0;
            o_core_func  <= cordic_func'(2'd0);
            o_core_data  <= cordic_data_in'(48'd0);
        end else begin
            o_core_valid <= grant_s;
            if (grant_s) begin
                ptr_r       <= grant_id_s;
                core_id_r   <= grant_id_s;
                o_core_func <= i_req_func[grant_id_s];
                o_core_data <= i_req_data[grant_id_s];
            end else begin
                ptr_r       <= ptr_r;
                core_id_r   <= core_id_r;
                o_core_func <= o_core_func;
                o_core_data <= o_core_data;
            end
        end
    end

    // Tag delay line: stage 0 follows the issue register, the tail lines up with the core output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tag_vld_r <= '0;
            for (int i = 0; i < CORE_LAT; i++) begin
                tag_id_r[i] <= '0;
            end
        end else begin
            tag_vld_r[0] <= o_core_valid;
            tag_id_r[0]  <= core_id_r;
            for (int i = 1; i < CORE_LAT; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_id_r[i]  <= tag_id_r[i-1];
            end
        end
    end

    // Response register: only results that meet a live tag are forwarded.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_data  <= cordic_data'(48'd0);
        end else begin
            o_rsp_valid <= i_core_valid & tail_vld_s;
            o_rsp_id    <= tail_id_s;
            o_rsp_data  <= i_core_data;
        end
    end

    // In-flight counter, saturating at both ends so a lost result cannot wrap it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_r <= '0;
        end else begin
            case ({grant_s, o_rsp_valid})
                2'b10: begin
                    if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                2'b01: begin
                    if (cnt_r != CNT_W'(0)) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign o_busy = (cnt_r != CNT_W'(0)) | o_core_valid;

    // Sticky error whenever the core's valid disagrees with the expected tag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (i_core_valid != tail_vld_s) begin
            o_err <= 1'b1;
        end else begin
            o_err <= o_err;
        end
    end

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Directed + random bench for cordic_rr_sched with a delay-line core model and a queue-based
// reference of grants, in-flight ops and expected responses.
module tb_cordic_rr_sched;
    import cordic_wrapper_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 14;
    localparam int IDW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    cordic_func    [N-1:0] req_func;
    cordic_data_in [N-1:0] req_data;
    logic [N-1:0]         req_ready;
    logic                 hold;
    logic                 core_valid_o;
    cordic_func           core_func;
    cordic_data_in        core_data;
    logic                 core_valid_i;
    cordic_data           core_data_i;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    cordic_data           rsp_data;
    logic                 busy;
    logic                 err;
    logic                 inject;

    always #5 clk = ~clk;

    cordic_rr_sched #(.NUM_REQ(N), .CORE_LAT(LAT), .ID_W(IDW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_func(req_func), .i_req_data(req_data),
        .o_req_ready(req_ready), .i_hold(hold),
        .o_core_valid(core_valid_o), .o_core_func(core_func), .o_core_data(core_data),
        .i_core_valid(core_valid_i), .i_core_data(core_data_i),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
        .o_busy(busy), .o_err(err)
    );

    function automatic cordic_data core_fn(cordic_func f, cordic_data_in d);
        cordic_data r;
        r.x = d.x ^ 16'h5a5a;
        r.y = d.y + d.z;
        r.z = d.z ^ {14'd0, f};
        return r;
    endfunction

    // Core stand-in: fixed LAT-cycle pipeline, reset together with the scheduler.
    logic [LAT-1:0] cm_vld;
    cordic_data     cm_dat [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) cm_vld <= '0;
        else     cm_vld <= {cm_vld[LAT-2:0], core_valid_o};
    end
    always @(posedge clk) begin
        cm_dat[0] <= core_fn(core_func, core_data);
        for (int i = 1; i < LAT; i++) cm_dat[i] <= cm_dat[i-1];
    end
    assign core_valid_i = cm_vld[LAT-1] | inject;
    assign core_data_i  = cm_dat[LAT-1];

    typedef struct { int id; cordic_data d; int due; } exp_t;
    exp_t          m_q[$];
    int            grant_log[$];
    int            m_ptr, cyc, n_cmp, n_bad;
    logic          m_cv, m_err;
    cordic_func    m_func;
    cordic_data_in m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ptr  = N - 1;
        m_cv   = 1'b0;
        m_err  = 1'b0;
        m_func = cordic_func'(2'd0);
        m_data = cordic_data_in'(48'd0);
        cyc    = 0;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic h);
        req_valid = v;
        hold      = h;
        for (int i = 0; i < N; i++) begin
            req_func[i]   = cordic_func'($urandom_range(0, 3));
            req_data[i].x = 16'($urandom);
            req_data[i].y = 16'($urandom);
            req_data[i].z = 16'($urandom);
        end
    endtask

    // Winner = valid requester at the smallest cyclic distance past the last winner.
    task automatic check_outputs(output int best);
        int bd;
        logic [N-1:0] er;
        logic exp_rv;
        logic [IDW-1:0] b;
        best = -1;
        bd   = N;
        for (int i = 0; i < N; i++) begin
            int d;
            d = (i - m_ptr - 1 + 2 * N) % N;
            if (req_valid[i] && !hold && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        er = '0;
        if (best >= 0) begin
            b = IDW'(best);
            er[b] = 1'b1;
        end
        grant_log.push_back(best);
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("core_valid", 64'(core_valid_o), 64'(m_cv));
        chk("core_func", 64'(core_func), 64'(m_func));
        chk("core_data", 64'(core_data), 64'(m_data));
        exp_rv = (m_q.size() > 0) && (m_q[0].due == cyc);
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk("rsp_id", 64'(rsp_id), 64'(m_q[0].id));
            chk("rsp_data", 64'(rsp_data), 64'(m_q[0].d));
        end
        chk("busy", 64'(busy), 64'((m_q.size() != 0) || m_cv));
        chk("err", 64'(err), 64'(m_err));
    endtask

    task automatic update(input int best);
        exp_t e;
        logic [IDW-1:0] b;
        if (m_q.size() > 0 && m_q[0].due == cyc) void'(m_q.pop_front());
        if (inject && !(m_q.size() > 0 && m_q[0].due == cyc + 1)) m_err = 1'b1;
        m_cv = (best >= 0);
        if (best >= 0) begin
            b      = IDW'(best);
            m_ptr  = best;
            m_func = req_func[b];
            m_data = req_data[b];
            e.id   = best;
            e.d    = core_fn(req_func[b], req_data[b]);
            e.due  = cyc + LAT + 2;
            m_q.push_back(e);
        end
        cyc++;
    endtask

    task automatic tick();
        int best;
        @(negedge clk);
        check_outputs(best);
        @(posedge clk);
        update(best);
        #1;
    endtask

    task automatic do_reset();
        drive('0, 1'b0);
        inject = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int w, maxw;
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        inject = 1'b0;
        drive('0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Single request from requester 2, then drain.
        drive(4'b0100, 1'b0);
        grant_log.delete();
        tick();
        chk("single_grant", 64'(grant_log[0]), 64'(2));
        drive('0, 1'b0);
        repeat (19) tick();

        // Full contention from reset: rotation 0,1,2,3,...
        do_reset();
        grant_log.delete();
        repeat (8) begin drive(4'b1111, 1'b0); tick(); end
        for (int i = 0; i < 8; i++) chk("rotation", 64'(grant_log[i]), 64'(i % 4));
        drive('0, 1'b0);
        repeat (20) tick();

        // Fairness between requesters 1 and 3.
        grant_log.delete();
        repeat (12) begin drive(4'b1010, 1'b0); tick(); end
        w = 0; maxw = 0;
        foreach (grant_log[i]) begin
            if (grant_log[i] == 3) w = 0;
            else w++;
            if (w > maxw) maxw = w;
        end
        chk("fair_wait_le1", 64'(maxw <= 1), 64'(1));
        drive('0, 1'b0);
        repeat (20) tick();

        // Hold with four ops in flight, then release to requester 0.
        repeat (4) begin drive(4'b1111, 1'b0); tick(); end
        repeat (20) begin drive(4'b0001, 1'b1); tick(); end
        #2;
        chk("hold_drained_busy", 64'(busy), 64'(0));
        drive(4'b0001, 1'b0);
        grant_log.delete();
        tick();
        chk("hold_release_grant", 64'(grant_log[0]), 64'(0));
        drive('0, 1'b0);
        repeat (20) tick();

        // Spurious core result with empty tag.
        inject = 1'b1;
        tick();
        inject = 1'b0;
        repeat (100) tick();
        chk("err_sticky", 64'(err), 64'(1));
        do_reset();
        tick();

        // Random traffic with occasional hold.
        for (int i = 0; i < 300; i++) begin
            drive(N'($urandom), ($urandom_range(0, 4) == 0));
            tick();
        end
        drive('0, 1'b0);
        repeat (20) tick();

        // Asynchronous reset in the middle of a burst.
        repeat (6) begin drive(4'b1111, 1'b0); tick(); end
        #3;
        rst = 1'b1;
        #1;
        chk("arst_core_valid", 64'(core_valid_o), 64'(0));
        chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        grant_log.delete();
        tick();
        chk("arst_first_grant", 64'(grant_log[0]), 64'(0));
        drive('0, 1'b0);
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
